// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command constants and timing helper
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERR
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    function automatic int us_to_cyc(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake between a host client and ps2_host_tx
interface ps2_host_tx_if;
    logic [7:0] TX_BYTE;
    logic       TX_VALID;
    logic       TX_READY;
    logic       TX_DONE;
    logic       TX_ERR;
    logic       BUSY;

    modport master (
        output TX_BYTE, TX_VALID,
        input  TX_READY, TX_DONE, TX_ERR, BUSY
    );

    modport slave (
        input  TX_BYTE, TX_VALID,
        output TX_READY, TX_DONE, TX_ERR, BUSY
    );
endinterface

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchronizer plus stability filter for one PS/2 line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    output logic level
);
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive synchronized samples that disagree with level_q
    always_comb begin
        s1_d    = pin_in;
        s2_d    = s1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with ACK check
// Optional PS2_HOST_TX_WATCHDOG_EN adds first-edge and frame timeouts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ           = 50_000_000,
    parameter int INHIBIT_US            = 120,
    parameter int REQ_US                = 5,
    parameter int FILTER_LEN            = 8,
    parameter int FIRST_EDGE_TIMEOUT_US = 15000,
    parameter int FRAME_TIMEOUT_US      = 2000
) (
    input  logic            CLK,
    input  logic            RST,
    ps2_host_tx_if.slave    tx,
    input  logic            PS2_CLK_IN,
    input  logic            PS2_DATA_IN,
    output logic            PS2_CLK_OE,
    output logic            PS2_DATA_OE
);
    localparam int INHIBIT_CYC    = us_to_cyc(CLK_FREQ_HZ, INHIBIT_US);
    localparam int REQ_CYC        = us_to_cyc(CLK_FREQ_HZ, REQ_US);
    localparam int FIRST_EDGE_CYC = us_to_cyc(CLK_FREQ_HZ, FIRST_EDGE_TIMEOUT_US);
    localparam int FRAME_CYC      = us_to_cyc(CLK_FREQ_HZ, FRAME_TIMEOUT_US);
    localparam int MAX_A          = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
    localparam int MAX_B          = (FIRST_EDGE_CYC > FRAME_CYC) ? FIRST_EDGE_CYC : FRAME_CYC;
    localparam int MAX_CYC        = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W          = $clog2(MAX_CYC + 1);

    logic clk_lvl, data_lvl, clk_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk(CLK), .rst(RST), .pin_in(PS2_CLK_IN), .level(clk_lvl)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk(CLK), .rst(RST), .pin_in(PS2_DATA_IN), .level(data_lvl)
    );

    ps2_tx_state_t    state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             parity_q, parity_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_prev_q, clk_prev_d;
`ifdef PS2_HOST_TX_WATCHDOG_EN
    logic [TMR_W-1:0] wd_limit;
`endif

    assign clk_fall = clk_prev_q & ~clk_lvl;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        byte_d     = byte_q;
        parity_d   = parity_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        ready_d    = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        err_d      = 1'b0;
        clk_prev_d = clk_lvl;
`ifdef PS2_HOST_TX_WATCHDOG_EN
        // Before the first device edge the long limit applies; afterwards the frame limit.
        wd_limit   = (bit_cnt_q == 4'd0) ? TMR_W'(FIRST_EDGE_CYC - 1) : TMR_W'(FRAME_CYC - 1);
`endif
        unique case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                ready_d   = 1'b1;
                if (tx.TX_VALID && ready_q) begin
                    state_d   = ST_INHIBIT;
                    byte_d    = tx.TX_BYTE;
                    parity_d  = ~^tx.TX_BYTE;
                    bit_cnt_d = '0;
                    timer_d   = '0;
                    clk_oe_d  = 1'b1;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (timer_q == TMR_W'(INHIBIT_CYC - 1)) begin
                    state_d   = ST_REQ;
                    timer_d   = '0;
                    data_oe_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_REQ: begin
                if (timer_q == TMR_W'(REQ_CYC - 1)) begin
                    state_d  = ST_SHIFT;
                    timer_d  = '0;
                    clk_oe_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (clk_fall) begin
`ifdef PS2_HOST_TX_WATCHDOG_EN
                    timer_d = (bit_cnt_q == 4'd0) ? '0 : timer_q + 1'b1;
`endif
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~byte_q[bit_cnt_q[2:0]];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (data_lvl) begin
                        state_d   = ST_ERR;
                        err_d     = 1'b1;
                        clk_oe_d  = 1'b0;
                        data_oe_d = 1'b0;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
`ifdef PS2_HOST_TX_WATCHDOG_EN
                else if (timer_q >= wd_limit) begin
                    state_d   = ST_ERR;
                    err_d     = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            ST_WAIT_IDLE: begin
                if (clk_lvl && data_lvl) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                end
`ifdef PS2_HOST_TX_WATCHDOG_EN
                else if (timer_q >= wd_limit) begin
                    state_d   = ST_ERR;
                    err_d     = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            ST_DONE, ST_ERR: begin
                state_d   = ST_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            byte_q     <= '0;
            parity_q   <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_q     <= byte_d;
            parity_q   <= parity_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign tx.TX_READY  = ready_q;
    assign tx.TX_DONE   = done_q;
    assign tx.TX_ERR    = err_q;
    assign tx.BUSY      = busy_q;
    assign PS2_CLK_OE   = clk_oe_q;
    assign PS2_DATA_OE  = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with an open-drain keyboard model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_oe, data_oe;
    logic clk_line, data_line;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;

    assign clk_line  = ~(clk_oe | dev_clk_low);
    assign data_line = ~(data_oe | dev_data_low);

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .CLK_FREQ_HZ(1_000_000),
        .FILTER_LEN (2)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .tx         (bus),
        .PS2_CLK_IN (clk_line),
        .PS2_DATA_IN(data_line),
        .PS2_CLK_OE (clk_oe),
        .PS2_DATA_OE(data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.TX_DONE === 1'b1) done_cnt++;
        if (bus.TX_ERR === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Keyboard model: 80-cycle clock, samples host data on each rising edge.
    task automatic dev_rx(input bit ack_low, input bit glitch, input bit check_lat,
                          input logic lat_oe, input int abort_after, output logic [10:0] rx);
        int n;
        rx = '0;
        n = 0;
        while (!clk_oe && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (clk_oe && n < 500) begin @(negedge clk); n++; end
        check("dev_req_seen", 32'(n < 500), 1);
        check("dev_start_bit", data_line, 0);
        repeat (10) @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            dev_clk_low = 1'b1;
            if (check_lat && k == 0) begin
                repeat (4) @(negedge clk);
                check("lat_4cyc", data_oe, 1);
                @(negedge clk);
                check("lat_5cyc", data_oe, lat_oe);
                repeat (35) @(negedge clk);
            end else begin
                repeat (40) @(negedge clk);
            end
            dev_clk_low = 1'b0;
            rx[k] = data_line;
            if (abort_after == k + 1) return;
            if (glitch && k == 3) begin
                repeat (15) @(negedge clk);
                dev_clk_low = 1'b1;
                @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
            if (k == 9 && ack_low) dev_data_low = 1'b1;
            repeat (20) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic send_frame(input string name, input logic [7:0] b, input logic [9:0] exp_frame,
                              input bit ack_low, input bit glitch, input bit check_lat,
                              input bit hold, input int abort_after);
        logic [10:0] rx;
        int d_at, clk_hi, n;
        done_cnt = 0;
        err_cnt  = 0;
        bus.TX_BYTE  = b;
        bus.TX_VALID = 1'b1;
        fork
            begin
                @(negedge clk);
                check({name, "_busy_t1"}, bus.BUSY, 1);
                check({name, "_clk_oe_t1"}, clk_oe, 1);
                if (hold) bus.TX_BYTE = 8'h00;
                else bus.TX_VALID = 1'b0;
                d_at = 0; clk_hi = 0; n = 1;
                while (clk_oe && n < 400) begin
                    clk_hi++;
                    if (data_oe && d_at == 0) d_at = n;
                    @(negedge clk);
                    n++;
                end
                if (check_lat) begin
                    check({name, "_clk_oe_len"}, clk_hi, 125);
                    check({name, "_data_oe_at"}, d_at, 121);
                end
                if (abort_after == 0) begin
                    n = 0;
                    while (!(bus.TX_DONE || bus.TX_ERR) && n < 3000) begin @(negedge clk); n++; end
                    check({name, "_end_seen"}, 32'(n < 3000), 1);
                    if (hold) bus.TX_VALID = 1'b0;
                    @(negedge clk);
                    check({name, "_ready_after"}, bus.TX_READY, 1);
                end
            end
            dev_rx(ack_low, glitch, check_lat, ~b[0], abort_after, rx);
        join
        if (abort_after > 0) begin
            check({name, "_rx_partial"}, rx[3:0], exp_frame[3:0]);
        end else begin
            check({name, "_rx_frame"}, rx[9:0], exp_frame);
            repeat (3) @(negedge clk);
            check({name, "_done_cnt"}, done_cnt, ack_low ? 1 : 0);
            check({name, "_err_cnt"}, err_cnt, ack_low ? 0 : 1);
            check({name, "_oe_released"}, {clk_oe, data_oe}, 0);
            check({name, "_busy_end"}, bus.BUSY, 0);
        end
    endtask

    initial begin
        int j;
        rst = 1'b1;
        bus.TX_VALID = 1'b0;
        bus.TX_BYTE  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.TX_READY, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_oe", {clk_oe, data_oe}, 0);
        check("rst_pulses", {bus.TX_DONE, bus.TX_ERR}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.TX_READY, 1);

        send_frame("ed",     PS2_CMD_SET_LEDS, 10'b11_1110_1101, 1, 0, 1, 0, 0);
        send_frame("f4",     PS2_CMD_ENABLE,   10'b10_1111_0100, 1, 0, 0, 0, 0);
        send_frame("zero",   8'h00,            10'b11_0000_0000, 1, 0, 0, 0, 0);
        send_frame("nack",   PS2_CMD_ECHO,     10'b11_1110_1110, 0, 0, 0, 0, 0);
        send_frame("glitch", 8'hA5,            10'b11_1010_0101, 1, 1, 0, 0, 0);

        send_frame("abort",  8'h55,            10'b11_0101_0101, 1, 0, 0, 0, 4);
        check("abort_data_oe", data_oe, 1);
        check("abort_busy", bus.BUSY, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_oe", {clk_oe, data_oe}, 0);
        check("abort_busy_rst", bus.BUSY, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_err", err_cnt, 0);
        check("abort_ready", bus.TX_READY, 1);

        send_frame("ff",     PS2_CMD_RESET,    10'b11_1111_1111, 1, 0, 0, 0, 0);
        send_frame("hold",   PS2_CMD_ENABLE,   10'b10_1111_0100, 1, 0, 0, 1, 0);

        // No device activity at all after the request.
        done_cnt = 0;
        err_cnt  = 0;
        bus.TX_BYTE  = PS2_CMD_ENABLE;
        bus.TX_VALID = 1'b1;
        @(negedge clk);
        bus.TX_VALID = 1'b0;
        j = 0;
        while (clk_oe && j < 300) begin @(negedge clk); j++; end
`ifdef PS2_HOST_TX_WATCHDOG_EN
        j = 0;
        while (!bus.TX_ERR && j < 16000) begin @(negedge clk); j++; end
        check("wd_err_delay", j, 15000);
        @(negedge clk);
        check("wd_oe", {clk_oe, data_oe}, 0);
        check("wd_ready", bus.TX_READY, 1);
        check("wd_no_done", done_cnt, 0);
`else
        repeat (16000) @(negedge clk);
        check("nowd_busy", bus.BUSY, 1);
        check("nowd_no_err", err_cnt, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("nowd_ready", bus.TX_READY, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
